// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 oversampling UART receiver feeding a show-ahead byte FIFO.
// Latency: rx falling edge to byte readable = 2 + CLOCK_DIVIDE/2 + 9*CLOCK_DIVIDE + 1 clocks.
// Backpressure: none toward the line; a byte completing into a full FIFO without a pop is dropped and flags overrun.
module uart_rx_fifo #(
  parameter  int CLOCK_DIVIDE = 10416,
  parameter  int FIFO_DEPTH   = 8,
  localparam int CW           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,      // synchronous, active-high
  input  logic          rx,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          frame_err,
  output logic          overrun,
  input  logic          clr_err
);

  localparam int PW = $clog2(FIFO_DEPTH);

  // Bit-timer compare points: half a bit to reach the middle of the start
  // bit, then whole bits from there so every later sample is mid-bit too.
  localparam logic [13:0] HALF_M1 = 14'(CLOCK_DIVIDE / 2 - 1);
  localparam logic [13:0] FULL_M1 = 14'(CLOCK_DIVIDE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // ---------------------------------------------------------------------
  // Line synchroniser
  // ---------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_s_q;

  // Two-flop synchroniser; both flops reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------
  // Deframer FSM
  // ---------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  sh_q, sh_d;
  logic        push;
  logic        frame_set;

  // Deframer state registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      sh_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      sh_q      <= sh_d;
    end
  end

  // Next-state logic: bit timing, mid-bit sampling and the push/error strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 14'd1;
    bit_idx_d = bit_idx_q;
    sh_d      = sh_q;
    push      = 1'b0;
    frame_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            // Line went back high before mid start bit: treat as noise.
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          sh_d      = {rx_s_q, sh_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Bad stop bit: drop the byte and wait out a possible break so a
            // line held low cannot be decoded as a stream of 0x00 frames.
            frame_set = 1'b1;
            state_d   = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop;
  logic          wr_ok;
  logic          ovr_set;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign count   = count_q;
  assign rd_data = empty ? 8'h00 : mem_q[rptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // alongside a pop is accepted rather than counted as an overrun.
  assign pop     = rd_en && !empty;
  assign wr_ok   = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  // Pointer, occupancy and sticky-flag next state.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;

    if (wr_ok) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end

    case ({wr_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Clear first so a coinciding set event takes priority.
    if (clr_err) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (frame_set) begin
      frame_err_d = 1'b1;
    end
    if (ovr_set) begin
      overrun_d = 1'b1;
    end
  end

  // FIFO control and flag registers; reset flushes the queue by pointer.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Storage array; contents need no reset because empty masks rd_data.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wptr_q] <= sh_q;
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios plus random frames against a queue model.
// Runs with CLOCK_DIVIDE=16, FIFO_DEPTH=4.
// Inputs driven 1 time unit after posedge; outputs sampled at the same point.
module tb_uart_rx_fifo;

  localparam int CD = 16;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk;
  logic          rst_n;
  logic          rx;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          frame_err;
  logic          overrun;
  logic          clr_err;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: byte queue plus sticky flags.
  logic [7:0] mq[$];
  logic       m_ferr;
  logic       m_ovr;

  uart_rx_fifo #(
    .CLOCK_DIVIDE(CD),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .frame_err(frame_err),
    .overrun  (overrun),
    .clr_err  (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] exp_head;
    exp_head = (mq.size() > 0) ? mq[0] : 8'h00;
    chk({tag, "/empty"},     32'(empty),     32'(mq.size() == 0));
    chk({tag, "/full"},      32'(full),      32'(mq.size() == D));
    chk({tag, "/count"},     32'(count),     32'(mq.size()));
    chk({tag, "/rd_data"},   32'(rd_data),   32'(exp_head));
    chk({tag, "/frame_err"}, 32'(frame_err), 32'(m_ferr));
    chk({tag, "/overrun"},   32'(overrun),   32'(m_ovr));
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  // One 8N1 frame starting right after the current edge (edge T0).
  // The stop sample happens at edge T0+3+CD/2+9*CD = T0+155.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input bit pop_at_push, input bit chk_lat);
    rx = 1'b0;
    repeat (CD) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CD) tick();
    end
    rx = stop_bit;
    repeat (10) tick();
    if (chk_lat) chk("latency_edge154_empty", 32'(empty), 32'd1);
    if (pop_at_push) rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (chk_lat) chk("latency_edge155_empty", 32'(empty), 32'd0);
    if (stop_bit) begin
      if (pop_at_push && mq.size() > 0) begin
        void'(mq.pop_front());
        mq.push_back(b);
      end else if (mq.size() == D) begin
        m_ovr = 1'b1;
      end else begin
        mq.push_back(b);
      end
    end else begin
      m_ferr = 1'b1;
    end
    repeat (CD - 11) tick();
  endtask

  initial begin
    logic [7:0] rb;
    rst_n   = 1'b1;
    rx      = 1'b1;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;

    // Reset state
    repeat (3) tick();
    check_all("reset_held");
    rst_n = 1'b0;
    repeat (3) tick();
    check_all("reset_released");

    // 1: single byte with exact latency
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    chk("t1_rd_data", 32'(rd_data), 32'h0000_00A5);
    chk("t1_count", 32'(count), 32'd1);
    check_all("t1_after_frame");
    pop_one();
    check_all("t1_after_pop");

    // 2: five back-to-back frames, no pops
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b0, 1'b0);
      check_all("t2_frame");
    end
    chk("t2_overrun", 32'(overrun), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_pop_order", 32'(rd_data), 32'(i));
      pop_one();
    end
    check_all("t2_drained");
    pop_one();
    check_all("t2_pop_on_empty");
    clr_pulse();
    check_all("t2_clr");

    // 3: 5-clock glitch
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    repeat (30) tick();
    check_all("t3_glitch");

    // 4: framing error, line held low, then recovery
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (40) tick();
    rx = 1'b1;
    repeat (20) tick();
    chk("t4_frame_err", 32'(frame_err), 32'd1);
    check_all("t4_after_break");
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
    chk("t4_good_byte", 32'(rd_data), 32'h0000_007E);
    check_all("t4_recovered");
    clr_pulse();
    check_all("t4_clr");
    pop_one();

    // 5: pop coinciding with push while full
    for (int i = 0; i < D; i++) begin
      rb = 8'($urandom);
      send_frame(rb, 1'b1, 1'b0, 1'b0);
    end
    check_all("t5_full");
    send_frame(8'h99, 1'b1, 1'b1, 1'b0);
    chk("t5_no_overrun", 32'(overrun), 32'd0);
    chk("t5_count", 32'(count), 32'd4);
    check_all("t5_after_push_pop");
    for (int i = 0; i < D - 1; i++) begin
      pop_one();
      check_all("t5_drain");
    end
    chk("t5_last_byte", 32'(rd_data), 32'h0000_0099);
    pop_one();
    check_all("t5_empty");

    // 6: reset mid-DATA with 2 bytes queued
    send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
    send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
    check_all("t6_queued");
    rx = 1'b0;
    repeat (CD + 3 * CD + 5) tick();
    rx    = 1'b1;
    rst_n = 1'b1;
    repeat (2) tick();
    rst_n = 1'b0;
    mq.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    check_all("t6_after_reset");
    repeat (5) tick();
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    chk("t6_byte", 32'(rd_data), 32'h0000_0055);
    check_all("t6_recovered");
    pop_one();

    // Random frames with random pops and flag clears
    for (int it = 0; it < 16; it++) begin
      rb = 8'($urandom);
      send_frame(rb, 1'b1, ($urandom_range(0, 3) == 0), 1'b0);
      check_all("rand_frame");
      for (int p = 0; p < int'($urandom_range(0, 2)); p++) begin
        pop_one();
        check_all("rand_pop");
      end
      if ($urandom_range(0, 3) == 0) begin
        clr_pulse();
        check_all("rand_clr");
      end
      repeat ($urandom_range(0, 6)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
